// File: rtl/uart_cmd_responder_if.sv
// Byte handshake between uart_rx/uart_tx and the command responder.
// master = UART side (host byte source / transmitter), slave = responder.
interface uart_cmd_responder_if;
    logic [7:0] rx_data_in;
    logic       rx_done;
    logic [7:0] tx_data_out;
    logic       start_tx;
    logic       tx_done;

    modport master (
        output rx_data_in,
        output rx_done,
        output tx_done,
        input  tx_data_out,
        input  start_tx
    );

    modport slave (
        input  rx_data_in,
        input  rx_done,
        input  tx_done,
        output tx_data_out,
        output start_tx
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Parses write (57 addr data) / read (52 addr) frames into a 16 x 8 register file and answers with one byte.
// Optional: define UART_CMD_CHECKSUM_EN for a trailing XOR checksum byte per frame.
module uart_cmd_responder #(
    parameter int         TIMEOUT_CYCLES = 520833,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_cmd_responder_if.slave   bus,
    output logic [7:0]            ctrl_out,
    output logic                  frame_err
);

    localparam int         TW            = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0] OP_WRITE      = 8'h57;
    localparam logic [7:0] OP_READ       = 8'h52;
    localparam logic [7:0] MAX_ADDR      = 8'h0F;

`ifdef UART_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, GET_CSUM, EXEC, SEND, WAIT_TX
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_TX
    } state_t;
`endif

    state_t          state;
    logic [7:0]      regs [16];
    logic [7:0]      addr;
    logic [7:0]      data;
    logic            is_write;
    logic            op_bad;
    logic [TW-1:0]   timer;
    logic [7:0]      tx_data_q;
    logic            start_tx_q;
    logic            exec_nak;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]      csum_acc;
    logic            csum_bad;
`endif

    assign bus.tx_data_out = tx_data_q;
    assign bus.start_tx    = start_tx_q;
    assign ctrl_out        = regs[0];

`ifdef UART_CMD_CHECKSUM_EN
    assign exec_nak = op_bad || (addr > MAX_ADDR) || csum_bad;
`else
    assign exec_nak = op_bad || (addr > MAX_ADDR);
`endif

    // Single FSM; start_tx and frame_err default low so they only ever pulse for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            data       <= '0;
            is_write   <= 1'b0;
            op_bad     <= 1'b0;
            timer      <= '0;
            tx_data_q  <= '0;
            start_tx_q <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            csum_acc   <= '0;
            csum_bad   <= 1'b0;
`endif
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            start_tx_q <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (bus.rx_done) begin
                        is_write <= (bus.rx_data_in == OP_WRITE);
                        op_bad   <= (bus.rx_data_in != OP_WRITE) && (bus.rx_data_in != OP_READ);
`ifdef UART_CMD_CHECKSUM_EN
                        csum_acc <= bus.rx_data_in;
                        csum_bad <= 1'b0;
`endif
                        if ((bus.rx_data_in == OP_WRITE) || (bus.rx_data_in == OP_READ)) begin
                            state <= GET_ADDR;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end

`ifdef UART_CMD_CHECKSUM_EN
                GET_ADDR, GET_DATA, GET_CSUM: begin
`else
                GET_ADDR, GET_DATA: begin
`endif
                    if (bus.rx_done) begin
                        timer <= '0;
`ifdef UART_CMD_CHECKSUM_EN
                        csum_acc <= csum_acc ^ bus.rx_data_in;
`endif
                        case (state)
                            GET_ADDR: begin
                                addr <= bus.rx_data_in;
                                if (is_write) begin
                                    state <= GET_DATA;
                                end else begin
`ifdef UART_CMD_CHECKSUM_EN
                                    state <= GET_CSUM;
`else
                                    state <= EXEC;
`endif
                                end
                            end
                            GET_DATA: begin
                                data <= bus.rx_data_in;
`ifdef UART_CMD_CHECKSUM_EN
                                state <= GET_CSUM;
`else
                                state <= EXEC;
`endif
                            end
                            default: begin
`ifdef UART_CMD_CHECKSUM_EN
                                // XOR of every frame byte including the checksum is zero when intact.
                                csum_bad <= ((csum_acc ^ bus.rx_data_in) != 8'h00);
`endif
                                state <= EXEC;
                            end
                        endcase
                    end else if (timer >= TIMEOUT_LIMIT) begin
                        // Abandon the partial frame silently apart from the error pulse.
                        state     <= IDLE;
                        timer     <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                EXEC: begin
                    if (exec_nak) begin
                        tx_data_q <= NAK_BYTE;
                        frame_err <= 1'b1;
                    end else if (is_write) begin
                        regs[addr[3:0]] <= data;
                        tx_data_q       <= ACK_BYTE;
                    end else begin
                        tx_data_q <= regs[addr[3:0]];
                    end
                    if (bus.rx_done) begin
                        frame_err <= 1'b1;
                    end
                    start_tx_q <= 1'b1;
                    state      <= SEND;
                end

                SEND: begin
                    if (bus.rx_done) begin
                        frame_err <= 1'b1;
                    end
                    state <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (bus.rx_done) begin
                        frame_err <= 1'b1;
                    end
                    if (bus.tx_done) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: stimulus pushes expected responses, a monitor pops and compares.
// Honours UART_CMD_CHECKSUM_EN by appending checksum bytes and running the checksum-mismatch case.
module tb_uart_cmd_responder;

    localparam int T = 40;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ctrl_out;
    logic       frame_err;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_k = 0;
    int   starts_seen = 0;
    int   dones_issued = 0;
    exp_t exp_q[$];

    uart_cmd_responder_if bus();

    uart_cmd_responder #(.TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ctrl_out (ctrl_out),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%02h required=%02h", name, actual, expected);
        end
    endtask

    task automatic check_event(input logic is_err, input logic [7:0] data);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_%s actual=%02h required=none cyc=%0d", is_err ? "frame_err" : "start_tx", data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_err !== is_err || (!is_err && e.data !== data) || (e.cyc >= 0 && e.cyc != cyc)) begin
                failures++;
                $display("[TB] FAIL event actual=%s/%02h@%0d required=%s/%02h@%0d",
                         is_err ? "err" : "tx", data, cyc, e.is_err ? "err" : "tx", e.data, e.cyc);
            end
        end
    endtask

    // Monitor: frame_err is scored before start_tx when both land in the same cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) check_event(1'b1, 8'h00);
            if (bus.start_tx) begin
                check_event(1'b0, bus.tx_data_out);
                checks++;
                if (starts_seen != dones_issued) begin
                    failures++;
                    $display("[TB] FAIL start_while_busy actual=%0d required=%0d", starts_seen, dones_issued);
                end
                starts_seen++;
            end
        end
    end

    // Transmitter model: finishes each byte five cycles after start_tx.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.start_tx) begin
                repeat (5) @(negedge clk);
                bus.tx_done = 1'b1;
                @(negedge clk);
                bus.tx_done = 1'b0;
                dones_issued++;
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data_in = b;
        bus.rx_done    = 1'b1;
        last_k         = cyc;
        @(negedge clk);
        bus.rx_done    = 1'b0;
    endtask

    task automatic push_resp(input logic [7:0] resp, input logic nak);
        if (nak) exp_q.push_back('{is_err: 1'b1, data: 8'h00, cyc: last_k + 2});
        exp_q.push_back('{is_err: 1'b0, data: resp, cyc: last_k + 2});
    endtask

    task automatic send_write(input logic [7:0] a, input logic [7:0] d, input logic [7:0] resp, input logic nak);
        apply_stimulus(8'h57);
        apply_stimulus(a);
        apply_stimulus(d);
`ifdef UART_CMD_CHECKSUM_EN
        apply_stimulus(8'h57 ^ a ^ d);
`endif
        push_resp(resp, nak);
    endtask

    task automatic send_read(input logic [7:0] a, input logic [7:0] resp, input logic nak);
        apply_stimulus(8'h52);
        apply_stimulus(a);
`ifdef UART_CMD_CHECKSUM_EN
        apply_stimulus(8'h52 ^ a);
`endif
        push_resp(resp, nak);
    endtask

    task automatic gap();
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.rx_done    = 1'b0;
        bus.rx_data_in = 8'h00;
        repeat (3) @(negedge clk);
        check_output("reset_tx_data_out", bus.tx_data_out, 8'h00);
        check_output("reset_start_tx", {7'd0, bus.start_tx}, 8'h00);
        check_output("reset_frame_err", {7'd0, frame_err}, 8'h00);
        check_output("reset_ctrl_out", ctrl_out, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_write(8'h03, 8'hA5, 8'h06, 1'b0);
        gap();
        send_read(8'h03, 8'hA5, 1'b0);
        gap();

        send_write(8'h00, 8'h3C, 8'h06, 1'b0);
        check_output("ctrl_out_before_exec", ctrl_out, 8'h00);
        @(negedge clk);
        check_output("ctrl_out_after_write", ctrl_out, 8'h3C);
        gap();
        send_read(8'h00, 8'h3C, 1'b0);
        gap();

        apply_stimulus(8'h41);
        push_resp(8'h15, 1'b1);
        gap();

        send_read(8'h10, 8'h15, 1'b1);
        gap();
        send_read(8'h03, 8'hA5, 1'b0);
        gap();

        exp_q.push_back('{is_err: 1'b1, data: 8'h00, cyc: -1});
        apply_stimulus(8'h57);
        apply_stimulus(8'h05);
        repeat (T + 20) @(negedge clk);
        send_read(8'h05, 8'h00, 1'b0);
        gap();

        send_write(8'h04, 8'h5A, 8'h06, 1'b0);
        @(negedge clk);
        exp_q.push_back('{is_err: 1'b1, data: 8'h00, cyc: -1});
        apply_stimulus(8'hFF);
        gap();
        send_read(8'h04, 8'h5A, 1'b0);
        gap();

`ifdef UART_CMD_CHECKSUM_EN
        apply_stimulus(8'h57);
        apply_stimulus(8'h02);
        apply_stimulus(8'h11);
        apply_stimulus(8'h00);
        push_resp(8'h15, 1'b1);
        gap();
        send_read(8'h02, 8'h00, 1'b0);
        gap();
`endif

        apply_stimulus(8'h57);
        apply_stimulus(8'h07);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_output("midframe_tx_data_out", bus.tx_data_out, 8'h00);
        check_output("midframe_start_tx", {7'd0, bus.start_tx}, 8'h00);
        check_output("midframe_frame_err", {7'd0, frame_err}, 8'h00);
        check_output("midframe_ctrl_out", ctrl_out, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_read(8'h03, 8'h00, 1'b0);
        gap();

        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL queue_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
